mem_arbiter: RTL and testbench

- Shares the single external memory port between I-cache miss traffic (read-only) and D-cache miss/writeback traffic (read or write).
- Sits between both caches and the memory model, below the pipeline.
- Registers each granted request, holds it on the memory port until the memory signals completion, then returns read data with a one-cycle ready pulse to the granted cache.
- Round-robin arbitration when both caches request in the same cycle.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between I-cache reads
// and D-cache reads/writes; one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner_d;
  logic                r_last_d;
  logic                r_is_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_i_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic w_d_req;
  logic w_any_req;
  logic w_grant_d;

  assign w_d_req   = d_read | d_write;
  assign w_any_req = i_read | w_d_req;
  // D wins when alone, or on a tie when I was served last.
  assign w_grant_d = w_d_req & (~i_read | ~r_last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_next = BUSY;
      BUSY:    if (mem_ready) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    unique case (r_state)
      BUSY: begin
        mem_read  = ~r_is_write;
        mem_write = r_is_write;
      end
      DONE: begin
        i_ready = ~r_owner_d;
        d_ready = r_owner_d;
      end
      default: ;
    endcase
  end

  // A simultaneous read+write from the D-cache is treated as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner_d   <= 1'b0;
      r_last_d    <= 1'b1;
      r_is_write  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == IDLE && w_any_req) begin
      r_owner_d  <= w_grant_d;
      r_last_d   <= w_grant_d;
      r_is_write <= w_grant_d & d_write;
      r_mem_addr <= w_grant_d ? d_addr : i_addr;
      if (w_grant_d && d_write) r_mem_wdata <= d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == BUSY && mem_ready && !r_is_write) begin
      if (r_owner_d) r_d_rdata <= mem_rdata;
      else           r_i_rdata <= mem_rdata;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: two request agents and a variable-latency
// memory, checked every cycle against a cycle-timeline transaction model.
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction model: timeline of the open transaction in cycle numbers.
  int            cyc = 0;
  bit            t_open = 0;
  bit            t_own_d, t_wr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  int            t_grant, t_resp;
  bit            last_d = 1;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  int            n_done = 0, n_grant_i = 0, n_grant_d = 0;

  bit            i_pend = 0, d_pend = 0, force_both = 0;
  int            resp_cyc = -1;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit strobe_exp();
    return t_open && cyc > t_grant && (t_resp < 0 || cyc <= t_resp);
  endfunction

  function automatic bit ready_exp();
    return t_open && t_resp >= 0 && cyc == t_resp + 1;
  endfunction

  function automatic bit sample_ok();
    return !t_open || (t_resp >= 0 && cyc >= t_resp + 2);
  endfunction

  task automatic cycle_body();
    bit s_exp, r_exp, g_d;
    s_exp = strobe_exp();
    r_exp = ready_exp();
    chk("mem_read",  DW'(mem_read),  DW'(s_exp && !t_wr));
    chk("mem_write", DW'(mem_write), DW'(s_exp && t_wr));
    if (s_exp) begin
      chk("mem_addr", DW'(mem_addr), DW'(t_addr));
      if (t_wr) chk("mem_wdata", mem_wdata, t_wdata);
    end
    chk("i_ready", DW'(i_ready), DW'(r_exp && !t_own_d));
    chk("d_ready", DW'(d_ready), DW'(r_exp && t_own_d));
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);

    if (i_pend) begin
      if (i_ready) begin
        i_pend = 0; i_read = 0; n_done++;
      end else if ($urandom_range(0, 3) == 0) i_addr = AW'($urandom());
    end else if (force_both || $urandom_range(0, 3) != 0) begin
      i_pend = 1; i_read = 1; i_addr = AW'($urandom());
    end

    if (d_pend) begin
      if (d_ready) begin
        d_pend = 0; d_read = 0; d_write = 0; n_done++;
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr = AW'($urandom()); d_wdata = rand_line();
      end
    end else if (force_both || $urandom_range(0, 3) != 0) begin
      d_pend = 1;
      if (force_both || $urandom_range(0, 1) == 0) begin d_read = 1; d_write = 0; end
      else begin d_read = 0; d_write = 1; end
      d_addr = AW'($urandom()); d_wdata = rand_line();
    end
    force_both = 0;

    mem_ready = 0;
    mem_rdata = rand_line();
    if (mem_read || mem_write) begin
      if (resp_cyc < 0) resp_cyc = cyc + $urandom_range(0, 3);
      if (cyc == resp_cyc) begin mem_ready = 1; resp_cyc = -1; end
    end else begin
      resp_cyc = -1;
      if ($urandom_range(0, 7) == 0) mem_ready = 1;
    end

    if (s_exp && mem_ready) begin
      t_resp = cyc;
      if (!t_wr) begin
        if (t_own_d) exp_d_rdata = mem_rdata;
        else         exp_i_rdata = mem_rdata;
      end
    end
    if (sample_ok() && (i_read || d_read || d_write)) begin
      g_d     = (d_read || d_write) && (!i_read || !last_d);
      t_open  = 1; t_own_d = g_d; t_grant = cyc; t_resp = -1;
      t_wr    = g_d && d_write;
      t_addr  = g_d ? d_addr : i_addr;
      t_wdata = d_wdata;
      last_d  = g_d;
      if (g_d) n_grant_d++; else n_grant_i++;
    end
    cyc++;
  endtask

  task automatic reset_and_release();
    rst_n = 0;
    i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_pend = 0; d_pend = 0; resp_cyc = -1;
    t_open = 0; last_d = 1; exp_i_rdata = '0; exp_d_rdata = '0;
    #1;
    chk("rst_mem_read",  DW'(mem_read),  '0);
    chk("rst_mem_write", DW'(mem_write), '0);
    chk("rst_i_ready",   DW'(i_ready),   '0);
    chk("rst_d_ready",   DW'(d_ready),   '0);
    chk("rst_i_rdata",   i_rdata,        '0);
    chk("rst_d_rdata",   d_rdata,        '0);
    chk("rst_mem_addr",  DW'(mem_addr),  '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_strobe", DW'(mem_read | mem_write), '0);
    rst_n = 1;
    force_both = 1;
    cycle_body();
  endtask

  initial begin
    bit found;
    #2;
    reset_and_release();
    repeat (1500) begin @(posedge clk); #1; cycle_body(); end

    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      if (strobe_exp()) found = 1;
      else cycle_body();
    end
    chk("busy_found_for_reset", DW'(found), DW'(1));
    chk("pre_rst_strobe", DW'(mem_read | mem_write), DW'(1));
    reset_and_release();
    repeat (1500) begin @(posedge clk); #1; cycle_body(); end

    chk("progress", DW'(n_done >= 200), DW'(1));
    chk("both_served", DW'(n_grant_i > 50 && n_grant_d > 50), DW'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
